// File: rtl/coherence_ctrl.sv
// coherence_ctrl
//   Memory-side coherence controller shared by two data caches. Arbitrates
//   the per-core word request streams onto one RAM port. Before a read miss
//   is serviced, the other cache is snooped. That cache may write back a
//   dirty block or invalidate its copy before the requester reads from RAM.
//   A block is two words, and daddr[2] selects the word within a block.
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   dREN, dWEN          per-core word read / write requests
//   ccexcl              requester will write the block (other copies invalidated)
//   daddr, dstore       per-core word address and write data
//   snoophit/snoopdirty snooped cache holds ccsnoopaddr (clean / dirty)
//   dwait, dload        per-core word handshake and read data
//   ccwait              core is being snooped and must hold off its own requests
//   ccwrite, ccinv      snooped core must write back / invalidate its block
//   ccsnoopaddr         per-core snoop address
//   ramREN, ramWEN      RAM strobes
//   ramaddr, ramstore   RAM address and write data
//   ramload, ramwait    RAM read data and busy flag
//
// state | meaning
// IDLE  | arbitrate round-robin between requesting cores
// WB    | requester r writes its block to RAM (two words)
// SNOOP | one cycle: sample the snooped core s
// SWB   | snooped core s writes its dirty block to RAM, then RD
// INV   | one cycle: snooped core s drops its clean copy, then RD
// RD    | requester r reads its block from RAM (two words)
module coherence_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0]             ccexcl,
    input  logic [1:0][ADDR_W-1:0] daddr,
    input  logic [1:0][DATA_W-1:0] dstore,
    input  logic [1:0]             snoophit,
    input  logic [1:0]             snoopdirty,
    output logic [1:0]             dwait,
    output logic [1:0][DATA_W-1:0] dload,
    output logic [1:0]             ccwait,
    output logic [1:0]             ccwrite,
    output logic [1:0]             ccinv,
    output logic [1:0][ADDR_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [ADDR_W-1:0]      ramaddr,
    output logic [DATA_W-1:0]      ramstore,
    input  logic [DATA_W-1:0]      ramload,
    input  logic                   ramwait
);

    typedef enum logic [2:0] {IDLE, WB, SNOOP, SWB, INV, RD} state_t;

    state_t     state;
    logic       r;          // granted requester
    logic       s;          // the other (snooped) core
    logic       rr_last;    // last granted core
    logic       wc;         // word within the block
    logic       c;          // core currently driving the RAM port
    logic [1:0] cand;
    logic       gnt;
    logic       req_c;
    logic       done;

    assign s     = ~r;
    assign c     = (state == SWB) ? s : r;
    assign req_c = dREN[c] | dWEN[c];
    assign done  = (ramREN | ramWEN) & ~ramwait;

    // A core under snoop is not a candidate, even if it still asserts a request.
    assign cand = (dREN | dWEN) & ~ccwait;
    assign gnt  = (cand == 2'b11) ? ~rr_last : cand[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            r           <= 1'b0;
            rr_last     <= 1'b1;
            wc          <= 1'b0;
            ccsnoopaddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand != 2'b00) begin
                        r       <= gnt;
                        rr_last <= gnt;
                        if (dWEN[gnt]) begin
                            state <= WB;
                        end else begin
                            state             <= SNOOP;
                            ccsnoopaddr[~gnt] <= daddr[gnt];
                        end
                    end
                end
                WB, RD: begin
                    if (!req_c) begin
                        // The requester withdrew, so the block is abandoned.
                        state <= IDLE;
                        wc    <= 1'b0;
                    end else if (done) begin
                        wc <= ~wc;
                        if (wc) state <= IDLE;
                    end
                end
                SNOOP: begin
                    if (snoopdirty[s])
                        state <= SWB;
                    else if (snoophit[s] && ccexcl[r])
                        state <= INV;
                    else
                        state <= RD;
                end
                SWB: begin
                    if (done) begin
                        wc <= ~wc;
                        if (wc) state <= RD;
                    end
                end
                INV:     state <= RD;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dwait    = 2'b11;
        dload    = '0;
        ccwait   = 2'b00;
        ccwrite  = 2'b00;
        ccinv    = 2'b00;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            WB, RD, SWB: begin
                ramaddr  = daddr[c];
                ramstore = dstore[c];
                if (state == RD)
                    ramREN = dREN[c];
                else
                    ramWEN = dWEN[c];
                dwait[c] = ramwait;
                dload[c] = ramload;
                if (state == SWB) begin
                    ccwait[s]  = 1'b1;
                    ccwrite[s] = 1'b1;
                    ccinv[s]   = ccexcl[r];
                end
            end
            SNOOP: ccwait[s] = 1'b1;
            INV: begin
                ccwait[s] = 1'b1;
                ccinv[s]  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
